// File: rtl/pc_gen.sv
// pc_gen: instruction fetch PC generator.
//
// Issues one instruction-memory request at a time, presents the returned
// instruction to decode with a valid/ready handshake, and follows redirects
// from the branch unit. A redirect that arrives while a request is still
// outstanding cannot withdraw it, so the response is marked to be discarded
// and the redirect target is fetched once that response arrives.
//
// Ports:
//   clk             in   1   rising-edge clock
//   rst_n           in   1   synchronous active-low reset
//   redirect_valid  in   1   redirect request from the branch unit
//   redirect_target in  64   redirect destination, qualified by redirect_valid
//   ireq_valid      out  1   instruction memory request valid
//   ireq_addr       out 64   instruction memory request address
//   ireq_ok         in   1   response strobe, completes the outstanding request
//   ireq_data       in  32   instruction word, valid with ireq_ok
//   if_valid        out  1   instruction available to decode
//   if_pc           out 64   PC of the presented instruction
//   if_instr        out 32   presented instruction word
//   if_ready        in   1   decode accepts when if_valid && if_ready

module pc_gen #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_target,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        ireq_ok,
   input  logic [31:0] ireq_data,
   output logic        if_valid,
   output logic [63:0] if_pc,
   output logic [31:0] if_instr,
   input  logic        if_ready
);

   typedef enum logic [1:0] {StBoot, StFetch, StHold} state_e;

   state_e      state_q;
   logic        kill_q;       // outstanding response must be discarded
   logic [63:0] fetch_pc_q;
   logic [63:0] pending_pc_q; // where to go once the killed response returns
   logic [63:0] if_pc_q;
   logic [31:0] if_instr_q;

   logic [63:0] target_aligned;
   logic [63:0] pending_aligned;
   logic [63:0] reset_aligned;
   logic [63:0] seq_pc;

   assign target_aligned  = {redirect_target[63:2], 2'b00};
   assign pending_aligned = {pending_pc_q[63:2], 2'b00};
   assign reset_aligned   = {RESET_PC[63:2], 2'b00};
   assign seq_pc          = if_pc_q + 64'd4;  // wraps modulo 2^64

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StBoot;
         kill_q       <= 1'b0;
         fetch_pc_q   <= RESET_PC;
         pending_pc_q <= '0;
         if_pc_q      <= '0;
         if_instr_q   <= '0;
      end else begin
         unique case (state_q)
            StBoot: begin
               // Redirects and stray responses are ignored here.
               state_q    <= StFetch;
               kill_q     <= 1'b0;
               fetch_pc_q <= reset_aligned;
            end
            StFetch: begin
               if (ireq_ok) begin
                  if (redirect_valid) begin
                     // Current redirect beats any pending target.
                     kill_q     <= 1'b0;
                     fetch_pc_q <= target_aligned;
                  end else if (kill_q) begin
                     kill_q     <= 1'b0;
                     fetch_pc_q <= pending_aligned;
                  end else begin
                     if_pc_q    <= fetch_pc_q;
                     if_instr_q <= ireq_data;
                     state_q    <= StHold;
                  end
               end else if (redirect_valid) begin
                  // Request stays up until ireq_ok; last target wins.
                  kill_q       <= 1'b1;
                  pending_pc_q <= target_aligned;
               end
            end
            StHold: begin
               if (redirect_valid) begin
                  fetch_pc_q <= target_aligned;
                  state_q    <= StFetch;
               end else if (if_ready) begin
                  fetch_pc_q <= seq_pc;
                  state_q    <= StFetch;
               end
            end
            default: begin
               state_q <= StBoot;
               kill_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ireq_valid = (state_q == StFetch);
   assign ireq_addr  = fetch_pc_q;
   // A redirect squashes the held instruction in the same cycle.
   assign if_valid   = (state_q == StHold) && !redirect_valid;
   assign if_pc      = if_pc_q;
   assign if_instr   = if_instr_q;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

   logic        clk;
   logic        rst_n;
   logic        redirect_valid;
   logic [63:0] redirect_target;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        ireq_ok;
   logic [31:0] ireq_data;
   logic        if_valid;
   logic [63:0] if_pc;
   logic [31:0] if_instr;
   logic        if_ready;

   int unsigned n_checks;
   int unsigned n_fail;

   pc_gen #(
      .RESET_PC(64'h0000_0000_8000_0000)
   ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_target(redirect_target),
      .ireq_valid     (ireq_valid),
      .ireq_addr      (ireq_addr),
      .ireq_ok        (ireq_ok),
      .ireq_data      (ireq_data),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .if_ready       (if_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_fetch(input string tag, input logic [63:0] addr);
      check({tag, " ireq_valid"}, 64'(ireq_valid), 64'd1);
      check({tag, " ireq_addr"}, ireq_addr, addr);
      check({tag, " if_valid"}, 64'(if_valid), 64'd0);
   endtask

   task automatic chk_hold(input string tag, input logic [63:0] pc, input logic [31:0] ins);
      check({tag, " ireq_valid"}, 64'(ireq_valid), 64'd0);
      check({tag, " if_valid"}, 64'(if_valid), 64'd1);
      check({tag, " if_pc"}, if_pc, pc);
      check({tag, " if_instr"}, 64'(if_instr), 64'(ins));
   endtask

   initial begin
      n_checks        = 0;
      n_fail          = 0;
      rst_n           = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = '0;
      ireq_ok         = 1'b0;
      ireq_data       = '0;
      if_ready        = 1'b0;

      // Reset state
      step();
      step();
      check("rst ireq_valid", 64'(ireq_valid), 64'd0);
      check("rst if_valid", 64'(if_valid), 64'd0);
      check("rst if_pc", if_pc, 64'd0);
      check("rst if_instr", 64'(if_instr), 64'd0);
      rst_n = 1'b1;
      #1;
      check("boot ireq_valid", 64'(ireq_valid), 64'd0);
      check("boot if_valid", 64'(if_valid), 64'd0);

      // First fetch, response on the 2nd FETCH cycle
      step();
      chk_fetch("fetch0 c1", 64'h8000_0000);
      step();
      chk_fetch("fetch0 c2", 64'h8000_0000);
      ireq_ok   = 1'b1;
      ireq_data = 32'h0000_0013;
      step();
      ireq_ok = 1'b0;
      chk_hold("hold0", 64'h8000_0000, 32'h0000_0013);

      // Accept -> sequential fetch
      if_ready = 1'b1;
      step();
      if_ready = 1'b0;
      chk_fetch("seq", 64'h8000_0004);
      ireq_ok   = 1'b1;
      ireq_data = 32'h0010_0093;
      step();
      ireq_ok = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk_hold("stall", 64'h8000_0004, 32'h0010_0093);
         step();
      end
      chk_hold("stall end", 64'h8000_0004, 32'h0010_0093);

      // Redirect in HOLD: squashed combinationally, misaligned target rounded down
      redirect_valid  = 1'b1;
      redirect_target = 64'h8000_0103;
      if_ready        = 1'b1;
      #1;
      check("hold redir if_valid", 64'(if_valid), 64'd0);
      step();
      redirect_valid = 1'b0;
      if_ready       = 1'b0;
      chk_fetch("hold redir", 64'h8000_0100);

      // Redirect while request outstanding: addr held, response discarded
      redirect_valid  = 1'b1;
      redirect_target = 64'h8000_0200;
      step();
      redirect_valid = 1'b0;
      chk_fetch("kill c1", 64'h8000_0100);
      step();
      chk_fetch("kill c2", 64'h8000_0100);
      ireq_ok   = 1'b1;
      ireq_data = 32'hDEAD_BEEF;
      step();
      ireq_ok = 1'b0;
      chk_fetch("kill resp", 64'h8000_0200);

      // Two redirects, then a third coincident with ireq_ok
      redirect_valid  = 1'b1;
      redirect_target = 64'h8000_0300;
      step();
      redirect_target = 64'h8000_0400;
      step();
      chk_fetch("multi c2", 64'h8000_0200);
      redirect_target = 64'h8000_0500;
      ireq_ok         = 1'b1;
      step();
      redirect_valid = 1'b0;
      ireq_ok        = 1'b0;
      chk_fetch("coincident", 64'h8000_0500);

      // Last pending target wins and is aligned
      redirect_valid  = 1'b1;
      redirect_target = 64'h8000_0600;
      step();
      redirect_target = 64'h8000_0703;
      step();
      redirect_valid = 1'b0;
      ireq_ok        = 1'b1;
      step();
      ireq_ok = 1'b0;
      chk_fetch("pending", 64'h8000_0700);

      // Wrap of if_pc + 4
      redirect_valid  = 1'b1;
      redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
      ireq_ok         = 1'b1;
      step();
      redirect_valid = 1'b0;
      chk_fetch("top", 64'hFFFF_FFFF_FFFF_FFFC);
      ireq_data = 32'h0000_1234;
      step();
      ireq_ok = 1'b0;
      chk_hold("top hold", 64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_1234);
      if_ready = 1'b1;
      step();
      if_ready = 1'b0;
      chk_fetch("wrap", 64'h0);

      // Reset mid-FETCH; response and redirect during BOOT ignored
      rst_n = 1'b0;
      step();
      check("midrst ireq_valid", 64'(ireq_valid), 64'd0);
      check("midrst if_valid", 64'(if_valid), 64'd0);
      rst_n           = 1'b1;
      ireq_ok         = 1'b1;
      redirect_valid  = 1'b1;
      redirect_target = 64'h0000_0000_0012_3400;
      step();
      ireq_ok        = 1'b0;
      redirect_valid = 1'b0;
      chk_fetch("refetch c1", 64'h8000_0000);
      step();
      chk_fetch("refetch c2", 64'h8000_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
